ps2_scan_rx: RTL
================

Name: ps2_scan_rx

Overview:
- PS/2 keyboard receive stage that sits directly upstream of the beeper tone stage.
- Samples the raw PS2_CLK and PS2_DATA pins, deserialises 11-bit device-to-host frames, and tracks the F0 (break) and E0 (extended) prefixes.
- Presents a held 8-bit key code: the last make code while a key is down, or a fixed release code after it is let go.
- The tone stage consumes KEY directly: it holds the last value and maps 8'h70 to silence.

Parameters:
- TIMEOUT_CYC, 50000: idle CLK_50M cycles between PS2_CLK falling edges mid-frame before the frame is aborted (1 ms at 50 MHz).
- RELEASE_CODE, 8'h70: value driven on KEY after a break sequence.

Ports:
- CLK_50M  input  1  system clock, 50 MHz.
- RST_N  input  1  asynchronous active-low reset.
- PS2_CLK  input  1  raw PS/2 clock pin, asynchronous to CLK_50M.
- PS2_DATA  input  1  raw PS/2 data pin, asynchronous to CLK_50M.
- KEY  output  8  held key code (make code or RELEASE_CODE).
- KEY_EXT  output  1  1 when the last make code was E0-prefixed.
- KEY_VALID  output  1  one-cycle pulse when KEY/KEY_EXT are updated.
- FRAME_ERR  output  1  one-cycle pulse on a discarded frame.

Behaviour:
- Clock and reset: single clock domain CLK_50M; asynchronous active-low reset RST_N.
- Reset values: KEY=RELEASE_CODE, KEY_EXT=0, KEY_VALID=0, FRAME_ERR=0, FSM=IDLE, break/ext flags=0, watchdog=0.
- Reset mid-frame: partial frame and prefix flags are dropped.
- Synchronisers: both pins pass through 2-FF synchronisers, synchronisers reset to 1.
- Edge detect: a third register on the clock path; falling edge = prev 1 and current 0 on the synchronised clock.
- Sampling: data is sampled on the synchronised value in the edge-detect cycle.
- FSM:
  - IDLE: on falling edge, data=0 -> DATA with bit count 0; data=1 -> stay in IDLE (glitch/start error, no error pulse).
  - DATA: each falling edge shifts data in LSB first; after bit 7 -> PARITY.
  - PARITY: on falling edge, capture the parity bit -> STOP.
  - STOP: on falling edge, stop=1 (and parity ok) -> frame accepted; otherwise FRAME_ERR pulse. Return to IDLE either way.
- Watchdog:
  - Counts CLK_50M cycles in any state other than IDLE; cleared on every falling edge.
  - Reaching TIMEOUT_CYC-1 -> abort to IDLE, FRAME_ERR pulse, prefix flags cleared.
- Accepted-byte handling:
  - 8'hE0: set ext flag, no output.
  - 8'hF0: set break flag, no output.
  - Any other byte with break=1: KEY=RELEASE_CODE, KEY_EXT=0, KEY_VALID pulse, clear both flags.
  - Any other byte with break=0: KEY=byte, KEY_EXT=ext flag, KEY_VALID pulse, clear ext flag.
  - Typematic repeat of the same make code re-pulses KEY_VALID with an unchanged KEY.
- Latency: KEY/KEY_VALID/FRAME_ERR update exactly 4 CLK_50M cycles after the stop-bit falling edge at the pin (2 sync + edge register + output register).
- Pulse widths: KEY_VALID and FRAME_ERR are never asserted together and are exactly one cycle wide.
- Simultaneous events: a watchdog expiry and a falling edge in the same cycle -> the falling edge wins and the watchdog clears.

Optional Feature:
- PS2_PARITY_CHECK_EN defined:
  - Odd parity is checked over data+parity; a mismatch in STOP discards the byte with a FRAME_ERR pulse.
  - Prefix flags are unchanged by a discarded byte.
- Not defined:
  - The parity bit is clocked in and ignored; only the stop bit and the watchdog can raise FRAME_ERR.

Test Plan:
- Frame 8'h69 (parity 1, stop 1) at 12.5 kHz -> KEY=8'h69, KEY_EXT=0, one KEY_VALID pulse 4 cycles after the stop edge.
- Frames F0, 69 -> KEY=8'h70, one KEY_VALID (none for F0), break flag cleared; a following 8'h72 -> KEY=8'h72.
- Frames E0, 75 -> KEY=8'h75, KEY_EXT=1; then E0, F0, 75 -> KEY=8'h70, KEY_EXT=0.
- 8'h7A with wrong parity -> PS2_PARITY_CHECK_EN defined: FRAME_ERR pulse, KEY unchanged; undefined: KEY=8'h7A.
- Stop PS2_CLK after 5 data bits for 50000 cycles -> FRAME_ERR pulse, FSM IDLE; a following clean 8'h6B frame -> KEY=8'h6B.
- RST_N low after the 3rd data bit -> KEY=8'h70, no pulses; the next full 8'h73 frame decodes correctly.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin sync, 11-bit frame deserialiser, F0/E0 prefix tracking.
// Optional odd-parity checking is enabled with `define PS2_PARITY_CHECK_EN.
module ps2_scan_rx #(
    parameter int         TIMEOUT_CYC  = 50000,
    parameter logic [7:0] RELEASE_CODE = 8'h70
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] KEY,
    output logic       KEY_EXT,
    output logic       KEY_VALID,
    output logic       FRAME_ERR
);

    localparam int WDW = $clog2(TIMEOUT_CYC);
    localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t         state, state_n;
    logic           clk_s1, clk_s2, clk_s3;
    logic           dat_s1, dat_s2;
    logic           fall;
    logic [2:0]     cnt, cnt_n;
    logic [7:0]     sh, sh_n;
    logic           par, par_n;
    logic [WDW-1:0] wd, wd_n;
    logic           ok, ok_n;
    logic           bad, bad_n;
    logic           abort, abort_n;
    logic           par_ok;
    logic           brk, ext;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= PS2_DATA;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = clk_s3 & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{par, sh};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            par   <= 1'b0;
            wd    <= '0;
            ok    <= 1'b0;
            bad   <= 1'b0;
            abort <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            par   <= par_n;
            wd    <= wd_n;
            ok    <= ok_n;
            bad   <= bad_n;
            abort <= abort_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        par_n   = par;
        wd_n    = (state == IDLE) ? '0 : wd + 1'b1;
        ok_n    = 1'b0;
        bad_n   = 1'b0;
        abort_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall && !dat_s2) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    sh_n  = {dat_s2, sh[7:1]};
                    cnt_n = cnt + 3'd1;
                    if (cnt == 3'd7)
                        state_n = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    ok_n    = dat_s2 & par_ok;
                    bad_n   = ~(dat_s2 & par_ok);
                end
            end
        endcase
        // A falling edge in the expiry cycle keeps the frame alive
        if (fall) begin
            wd_n = '0;
        end else if (state != IDLE && wd == WD_LIM) begin
            state_n = IDLE;
            wd_n    = '0;
            bad_n   = 1'b1;
            abort_n = 1'b1;
        end
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            KEY       <= RELEASE_CODE;
            KEY_EXT   <= 1'b0;
            KEY_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
            brk       <= 1'b0;
            ext       <= 1'b0;
        end else begin
            KEY_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (abort) begin
                FRAME_ERR <= 1'b1;
                brk       <= 1'b0;
                ext       <= 1'b0;
            end else if (bad) begin
                FRAME_ERR <= 1'b1;
            end else if (ok) begin
                if (sh == 8'hE0) begin
                    ext <= 1'b1;
                end else if (sh == 8'hF0) begin
                    brk <= 1'b1;
                end else if (brk) begin
                    KEY       <= RELEASE_CODE;
                    KEY_EXT   <= 1'b0;
                    KEY_VALID <= 1'b1;
                    brk       <= 1'b0;
                    ext       <= 1'b0;
                end else begin
                    KEY       <= sh;
                    KEY_EXT   <= ext;
                    KEY_VALID <= 1'b1;
                    ext       <= 1'b0;
                end
            end
        end
    end

endmodule
